// File: rtl/tdm_demux_8.sv
// 8-slot serial TDM demultiplexer with frame_sync hunt/lock and a flywheel
// that rides over up to MISS_LIMIT-1 missing sync pulses.
module tdm_demux_8 #(
    parameter int MISS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din,
    input  logic       frame_sync,
    output logic [7:0] Y,
    output logic [2:0] sel,
    output logic       locked,
    output logic       frame_valid,
    output logic       sync_err
);

    typedef enum logic {HUNT, LOCK} state_t;

    localparam logic [2:0] MISS_LAST = 3'(MISS_LIMIT - 1);

    state_t     state, state_nxt;
    logic [7:0] shadow, shadow_nxt, y_nxt;
    logic [2:0] sel_nxt, miss, miss_nxt;
    logic       fv_nxt, se_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            shadow      <= 8'h00;
            Y           <= 8'h00;
            sel         <= 3'd0;
            miss        <= 3'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            Y           <= y_nxt;
            sel         <= sel_nxt;
            miss        <= miss_nxt;
            frame_valid <= fv_nxt;
            sync_err    <= se_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        y_nxt      = Y;
        sel_nxt    = sel;
        miss_nxt   = miss;
        fv_nxt     = 1'b0;
        se_nxt     = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_nxt[0] = din;
                        sel_nxt       = 3'd1;
                        miss_nxt      = 3'd0;
                        state_nxt     = LOCK;
                    end
                end
                LOCK: begin
                    if (frame_sync) begin
                        // A sync anywhere restarts the frame; off-slot-0 also flags an error
                        shadow_nxt[0] = din;
                        sel_nxt       = 3'd1;
                        miss_nxt      = 3'd0;
                        se_nxt        = (sel != 3'd0);
                    end else if (sel == 3'd0) begin
                        if (miss == MISS_LAST) begin
                            state_nxt = HUNT;
                            sel_nxt   = 3'd0;
                            miss_nxt  = 3'd0;
                        end else begin
                            shadow_nxt[0] = din;
                            sel_nxt       = 3'd1;
                            miss_nxt      = miss + 3'd1;
                        end
                    end else if (sel == 3'd7) begin
                        y_nxt   = {din, shadow[6:0]};
                        fv_nxt  = 1'b1;
                        sel_nxt = 3'd0;
                    end else begin
                        shadow_nxt[sel] = din;
                        sel_nxt         = sel + 3'd1;
                    end
                end
            endcase
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux_8.sv
// Directed self-checking bench for tdm_demux_8 (MISS_LIMIT = 2).
module tb_tdm_demux_8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] Y;
    logic [2:0] sel;
    logic       locked, frame_valid, sync_err;

    int n_chk = 0;
    int n_pass = 0;

    tdm_demux_8 #(.MISS_LIMIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .frame_sync(frame_sync),
        .Y(Y), .sel(sel), .locked(locked), .frame_valid(frame_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic slot(input logic fs, input logic d);
        @(negedge clk);
        en = 1'b1; frame_sync = fs; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0; frame_sync = 1'b0; din = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One 8-slot frame; frame_valid must appear only after slot 7 when a frame is expected
    task automatic send_frame(input logic [7:0] v, input logic sync, input logic gap,
                              input logic exp_fv, input logic [7:0] y_before);
        for (int k = 0; k < 8; k++) begin
            slot(sync && (k == 0), v[k]);
            chk($sformatf("fv_slot%0d", k), {7'b0, frame_valid}, {7'b0, exp_fv && (k == 7)});
            if (k == 7) chk("y_frame", Y, exp_fv ? v : y_before);
            if (gap) begin
                idle();
                chk("fv_gap", {7'b0, frame_valid}, 8'h00);
                chk("y_gap", Y, (exp_fv && k == 7) ? v : y_before);
            end
        end
    endtask

    initial begin
        // reset values, before any clock edge
        #1;
        chk("rst_y", Y, 8'h00);
        chk("rst_sel", {5'b0, sel}, 8'h00);
        chk("rst_lock", {7'b0, locked}, 8'h00);
        chk("rst_fv", {7'b0, frame_valid}, 8'h00);
        chk("rst_se", {7'b0, sync_err}, 8'h00);
        @(negedge clk); rst_n = 1'b1;

        // hunting: no sync means nothing is captured
        slot(1'b0, 1'b1);
        slot(1'b0, 1'b1);
        chk("hunt_sel", {5'b0, sel}, 8'h00);
        chk("hunt_lock", {7'b0, locked}, 8'h00);

        // basic frame 1,0,1,1,0,0,1,0 -> 4D
        send_frame(8'h4D, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("f1_lock", {7'b0, locked}, 8'h01);
        chk("f1_sel", {5'b0, sel}, 8'h00);
        idle();
        chk("f1_fv_drop", {7'b0, frame_valid}, 8'h00);
        chk("f1_y_hold", Y, 8'h4D);

        // back-to-back frames; fv checked every slot, so pulses are exactly 8 en-cycles apart
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8'h4D);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5);

        // en toggling between every slot
        send_frame(8'h4D, 1'b1, 1'b1, 1'b1, 8'h3C);

        // sync at sel=3: error pulse, partial frame dropped, new frame from sync slot (96)
        slot(1'b1, 1'b1);
        slot(1'b0, 1'b1);
        slot(1'b0, 1'b1);
        chk("se_pre_sel", {5'b0, sel}, 8'h03);
        slot(1'b1, 1'b0);
        chk("se_pulse", {7'b0, sync_err}, 8'h01);
        chk("se_no_fv", {7'b0, frame_valid}, 8'h00);
        chk("se_sel", {5'b0, sel}, 8'h01);
        chk("se_y_keep", Y, 8'h4D);
        for (int k = 1; k < 8; k++) begin
            slot(1'b0, 8'h96 >> k);
            if (k == 1) chk("se_drop", {7'b0, sync_err}, 8'h00);
        end
        chk("se_fv", {7'b0, frame_valid}, 8'h01);
        chk("se_y", Y, 8'h96);

        // two consecutive missed syncs: first frame flywheels, second miss unlocks
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8'h96);
        chk("miss1_lock", {7'b0, locked}, 8'h01);
        slot(1'b0, 1'b1);
        chk("miss2_lock", {7'b0, locked}, 8'h00);
        chk("miss2_sel", {5'b0, sel}, 8'h00);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 8'h5A);
        chk("miss_hunt_sel", {5'b0, sel}, 8'h00);
        send_frame(8'h11, 1'b1, 1'b0, 1'b1, 8'h5A);

        // asynchronous reset at sel=5
        for (int k = 0; k < 5; k++) slot(k == 0, 1'b1);
        chk("ar_pre_sel", {5'b0, sel}, 8'h05);
        @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_y", Y, 8'h00);
        chk("ar_sel", {5'b0, sel}, 8'h00);
        chk("ar_lock", {7'b0, locked}, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'h77, 1'b1, 1'b0, 1'b1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
